// File: rtl/redstone_pkg.sv
// redstone_pkg: shared types and constants for the repeater bank.
//   rep_state_e       : per-channel repeater state (idle / pending rise / pending fall)
//   MAX_DELAY_DEFAULT : default largest per-channel delay in ticks
//   delay_width()     : width of a per-channel delay field, minimum 1
package redstone_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PEND_ON  = 2'd1,
      ST_PEND_OFF = 2'd2
   } rep_state_e;

   localparam int unsigned MAX_DELAY_DEFAULT = 4;

   function automatic int unsigned delay_width(input int unsigned max_delay);
      return (max_delay > 1) ? $clog2(max_delay) : 1;
   endfunction

endpackage

// File: rtl/repeater_cell.sv
// repeater_cell: one redstone repeater channel (state machine plus delay down-counter).
// Optional feature macro: REPEATER_LOCK_EN (lock input honoured; otherwise ignored).
// Ports:
//   clk_i   : clock, all state changes on its rising edge
//   rst_i   : synchronous active-high reset
//   tick_i  : redstone-tick strobe, state advances only when set
//   in_i    : input level
//   delay_i : delay field, delay D = field + 1 ticks, sampled on the scheduling edge only
//   lock_i  : lock (side-powered repeater)
//   out_o   : registered output level
//   busy_o  : registered, set while a transition is pending
module repeater_cell
   import redstone_pkg::*;
#(
   parameter int unsigned DW   = 2,
   parameter logic        INIT = 1'b0
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          tick_i,
   input  logic          in_i,
   input  logic [DW-1:0] delay_i,
   input  logic          lock_i,
   output logic          out_o,
   output logic          busy_o
);

   rep_state_e    state_q, state_d;
   logic [DW-1:0] cnt_q, cnt_d;
   logic          out_q, out_d;
   logic          busy_q, busy_d;
   logic          lock_act;

`ifdef REPEATER_LOCK_EN
   assign lock_act = lock_i;
`else
   logic lock_unused;
   assign lock_unused = lock_i;
   assign lock_act    = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      if (tick_i) begin
         if (lock_act) begin
            // Lock overrides scheduling and completion; output holds.
            state_d = ST_IDLE;
            cnt_d   = '0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (in_i != out_q) begin
                     if (delay_i == '0) begin
                        out_d = in_i;
                     end else begin
                        // Counter starts at D-2 so the output lands on tick edge D.
                        state_d = in_i ? ST_PEND_ON : ST_PEND_OFF;
                        cnt_d   = delay_i - DW'(1);
                     end
                  end
               end
               ST_PEND_ON, ST_PEND_OFF: begin
                  // Input is not re-examined here: pulses are extended, not cancelled.
                  if (cnt_q == '0) begin
                     out_d   = (state_q == ST_PEND_ON);
                     state_d = ST_IDLE;
                  end else begin
                     cnt_d = cnt_q - DW'(1);
                  end
               end
               default: begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end
            endcase
         end
      end
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         out_q   <= INIT;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         busy_q  <= busy_d;
      end
   end

   assign out_o  = out_q;
   assign busy_o = busy_q;

endmodule

// File: rtl/repeater_bank.sv
// repeater_bank: NUM_CH independent redstone repeater channels sharing one clock and tick.
// Optional feature macro: REPEATER_LOCK_EN (per-channel lock honoured; otherwise i_lock ignored).
// Ports:
//   i_clk   : clock
//   i_rst   : synchronous active-high reset (o_out <= INIT, all channels idle)
//   i_tick  : redstone-tick strobe
//   i_in    : per-channel input level
//   i_delay : channel c delay field at [c*DW +: DW], delay D = field + 1 ticks
//   i_lock  : per-channel lock
//   o_out   : per-channel registered output level
//   o_busy  : per-channel pending-transition flag
module repeater_bank
   import redstone_pkg::*;
#(
   parameter int unsigned        NUM_CH    = 8,
   parameter int unsigned        MAX_DELAY = MAX_DELAY_DEFAULT,
   parameter logic [NUM_CH-1:0]  INIT      = '0,
   localparam int unsigned       DW        = delay_width(MAX_DELAY)
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_tick,
   input  logic [NUM_CH-1:0]    i_in,
   input  logic [NUM_CH*DW-1:0] i_delay,
   input  logic [NUM_CH-1:0]    i_lock,
   output logic [NUM_CH-1:0]    o_out,
   output logic [NUM_CH-1:0]    o_busy
);

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      repeater_cell #(
         .DW   (DW),
         .INIT (INIT[c])
      ) u_cell (
         .clk_i   (i_clk),
         .rst_i   (i_rst),
         .tick_i  (i_tick),
         .in_i    (i_in[c]),
         .delay_i (i_delay[c*DW +: DW]),
         .lock_i  (i_lock[c]),
         .out_o   (o_out[c]),
         .busy_o  (o_busy[c])
      );
   end

endmodule

// File: tb/tb_repeater_bank.sv
// tb_repeater_bank: directed self-checking bench for repeater_bank (NUM_CH=8, MAX_DELAY=4).
// Two instances share stimulus: dut_a with default INIT, dut_b with INIT=8'hA5.
// Builds with or without REPEATER_LOCK_EN; lock expectations follow the macro.
module tb_repeater_bank;

   logic        clk = 1'b0;
   logic        rst;
   logic        tick;
   logic [7:0]  in_v;
   logic [15:0] delay_v;
   logic [7:0]  lock_v;
   logic [7:0]  out_a, busy_a, out_b, busy_b;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   repeater_bank #(.NUM_CH(8), .MAX_DELAY(4)) dut_a (
      .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_in(in_v),
      .i_delay(delay_v), .i_lock(lock_v), .o_out(out_a), .o_busy(busy_a)
   );

   repeater_bank #(.NUM_CH(8), .MAX_DELAY(4), .INIT(8'hA5)) dut_b (
      .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_in(in_v),
      .i_delay(delay_v), .i_lock(lock_v), .o_out(out_b), .o_busy(busy_b)
   );

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Advance one clock and settle just after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] eo, eb;
      rst  = 1'b1;
      tick = 1'b0;
      in_v = '0;
      // ch0 field 2 (D=3), ch1 3 (D=4), ch2 1 (D=2), ch3 3 (D=4), ch4 3 (D=4)
      delay_v = 16'h03DE;
      lock_v  = '0;

      // Reset state
      step();
      check("rst_out_a", out_a, 8'h00);
      check("rst_busy_a", busy_a, 8'h00);
      check("rst_out_b", out_b, 8'hA5);
      check("rst_busy_b", busy_b, 8'h00);
      rst = 1'b0;

      // ch0 D=3 rising, tick every clock
`ifndef REPEATER_LOCK_EN
      lock_v = 8'hFF;
`endif
      tick = 1'b1;
      in_v = 8'h01;
      for (int e = 1; e <= 3; e++) begin
         step();
         check($sformatf("d3_out_e%0d", e), out_a, (e == 3) ? 8'h01 : 8'h00);
         check($sformatf("d3_busy_e%0d", e), busy_a, (e == 3) ? 8'h00 : 8'h01);
      end
      lock_v = '0;

      // ch1 D=4, single-tick input pulse stretched to 4 ticks
      in_v = 8'h03;
      for (int e = 1; e <= 8; e++) begin
         step();
         if (e == 1) in_v = 8'h01;
         eo = (e >= 4 && e <= 7) ? 8'h03 : 8'h01;
         eb = (e <= 3 || (e >= 5 && e <= 7)) ? 8'h02 : 8'h00;
         check($sformatf("pulse_out_e%0d", e), out_a, eo);
         check($sformatf("pulse_busy_e%0d", e), busy_a, eb);
      end

      // ch2 D=2, tick on every third clock
      in_v = 8'h05;
      for (int k = 1; k <= 7; k++) begin
         tick = (k % 3 == 0);
         step();
         eo = (k >= 6) ? 8'h05 : 8'h01;
         eb = (k >= 3 && k <= 5) ? 8'h04 : 8'h00;
         check($sformatf("gated_out_k%0d", k), out_a, eo);
         check($sformatf("gated_busy_k%0d", k), busy_a, eb);
      end

      // ch3 D=4, lock raised on the second tick
      tick = 1'b1;
      in_v = 8'h0D;
      step();
      check("lock_sched_busy", busy_a, 8'h08);
      lock_v = 8'h08;
      for (int e = 2; e <= 3; e++) begin
         step();
`ifdef REPEATER_LOCK_EN
         check($sformatf("locked_out_e%0d", e), out_a, 8'h05);
         check($sformatf("locked_busy_e%0d", e), busy_a, 8'h00);
`else
         check($sformatf("nolock_out_e%0d", e), out_a, 8'h05);
         check($sformatf("nolock_busy_e%0d", e), busy_a, 8'h08);
`endif
      end
      lock_v = '0;
      for (int u = 1; u <= 4; u++) begin
         step();
`ifdef REPEATER_LOCK_EN
         eo = (u == 4) ? 8'h0D : 8'h05;
         eb = (u <= 3) ? 8'h08 : 8'h00;
`else
         eo = 8'h0D;
         eb = 8'h00;
`endif
         check($sformatf("unlock_out_u%0d", u), out_a, eo);
         check($sformatf("unlock_busy_u%0d", u), busy_a, eb);
      end

      // ch4 pending, then hold on a non-tick clock, then reset discards it
      in_v = 8'h1D;
      step();
      check("rstp_busy", busy_a, 8'h10);
      tick = 1'b0;
      step();
      check("hold_out", out_a, 8'h0D);
      check("hold_busy", busy_a, 8'h10);
      rst = 1'b1;
      step();
      check("rstp_out_a", out_a, 8'h00);
      check("rstp_busy_a", busy_a, 8'h00);
      check("rstp_out_b", out_b, 8'hA5);
      check("rstp_busy_b", busy_b, 8'h00);
      rst = 1'b0;
      step();
      check("post_rst_out", out_a, 8'h00);
      check("post_rst_busy", busy_a, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
